trace_dedup_table: RTL and testbench

- Parametrised successor of the single-channel trace/hash memory controller used in the runtime-attestation path.
- Assigns each distinct control-flow trace word a unique sequential ID; repeated traces get back their existing ID.
- Adds a valid/ready handshake on both sides, an internal inferred bucket memory, generic bucket width, bucket-full overflow reporting, ID saturation, and a table-clear FSM.
- Sits between the trace hasher and the attestation log/MAC stage.

---
 rtl/trace_dedup_table.sv | 152 +++++++++++++++
 tb/tb_trace_dedup_table.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dedup_table.sv
// trace_dedup_table: hands out a sequential ID per distinct trace word, using a hashed
// multi-way bucket table with in-flight insert forwarding and a clear sweep.
module trace_dedup_table #(
    parameter int TRACE_W      = 32,
    parameter int HASH_W       = 13,
    parameter int CNT_W        = 13,
    parameter int WAYS         = 8,
    parameter int RECENT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TRACE_W-1:0] in_trace,
    input  logic [HASH_W-1:0]  in_hash,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TRACE_W-1:0] out_trace,
    output logic [CNT_W-1:0]   out_id,
    output logic               out_new,
    output logic               out_overflow,
    input  logic               clear_req,
    output logic               busy,
    output logic               table_full
);
    localparam int FW    = $clog2(WAYS + 1);
    localparam int WW    = $clog2(WAYS);
    localparam int DEPTH = 2 ** HASH_W;
    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;
    typedef struct packed {logic v; logic [HASH_W-1:0] h; logic [TRACE_W-1:0] t;} stage_t;
    typedef struct packed {logic [CNT_W-1:0] id; logic [TRACE_W-1:0] t;} entry_t;
    typedef struct packed {
        logic               v;
        logic [HASH_W-1:0]  h;
        logic [TRACE_W-1:0] t;
        logic [CNT_W-1:0]   id;
        logic [FW-1:0]      fill;
    } recent_t;
    state_t                     state_q, state_d;
    logic [HASH_W-1:0]          clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]           next_id_q, next_id_d;
    stage_t [2:0]               st_q, st_d;
    recent_t [RECENT_DEPTH-1:0] rb_q, rb_d;
    logic                       out_valid_q, out_valid_d, out_new_q, out_new_d, out_ovf_q, out_ovf_d;
    logic [TRACE_W-1:0]         out_trace_q, out_trace_d;
    logic [CNT_W-1:0]           out_id_q, out_id_d;
    entry_t [WAYS-1:0]          ent_mem [DEPTH];
    logic [FW-1:0]              fill_mem [DEPTH];
    entry_t [WAYS-1:0]          rd_ent_q;
    logic [FW-1:0]              rd_fill_q;
    logic                       adv, accept, idle, hit, ovf, ins;
    logic [CNT_W-1:0]           hit_id;
    logic [FW-1:0]              fill_eff;
    stage_t                     s3;
    always_comb begin
        adv      = !out_valid_q || out_ready;
        in_ready = state_q == RUN && !clear_req && adv;
        accept   = in_valid && in_ready;
        idle     = !st_q[0].v && !st_q[1].v && !st_q[2].v && !out_valid_q;
        s3       = st_q[2];
        hit      = 1'b0;
        hit_id   = '0;
        fill_eff = rd_fill_q;
        for (int w = 0; w < WAYS; w++)
            if (w < int'(rd_fill_q) && rd_ent_q[w].t == s3.t) begin
                hit    = 1'b1;
                hit_id = rd_ent_q[w].id;
            end
        // oldest to newest, so the latest in-flight insert decides the bucket fill
        for (int r = RECENT_DEPTH - 1; r >= 0; r--)
            if (rb_q[r].v && rb_q[r].h == s3.h) begin
                fill_eff = rb_q[r].fill;
                if (rb_q[r].t == s3.t) begin
                    hit    = 1'b1;
                    hit_id = rb_q[r].id;
                end
            end
        ovf         = !hit && (fill_eff == FW'(WAYS) || &next_id_q);
        ins         = s3.v && adv && !hit && !ovf;
        state_d     = state_q == CLEAR ? (&clr_addr_q ? RUN : CLEAR)
                    : state_q == RUN   ? (clear_req ? DRAIN : RUN)
                    : (idle ? CLEAR : DRAIN);
        clr_addr_d  = state_q == CLEAR ? clr_addr_q + 1'b1 : '0;
        next_id_d   = next_id_q;
        rb_d        = rb_q;
        st_d        = st_q;
        out_valid_d = out_valid_q;
        out_trace_d = out_trace_q;
        out_id_d    = out_id_q;
        out_new_d   = out_new_q;
        out_ovf_d   = out_ovf_q;
        if (adv) begin
            st_d        = {st_q[1:0], stage_t'{accept, in_hash, in_trace}};
            out_valid_d = s3.v;
            if (s3.v) begin
                out_trace_d = s3.t;
                out_id_d    = hit ? hit_id : ovf ? '1 : next_id_q;
                out_new_d   = ins;
                out_ovf_d   = ovf;
            end
        end
        if (ins) begin
            next_id_d = next_id_q + 1'b1;
            rb_d      = {rb_q[RECENT_DEPTH-2:0], recent_t'{1'b1, s3.h, s3.t, next_id_q, FW'(fill_eff + 1'b1)}};
        end
        if (state_q == CLEAR) begin
            next_id_d = '0;
            rb_d      = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (ins) ent_mem[s3.h][fill_eff[WW-1:0]] <= entry_t'{next_id_q, s3.t};
        if (state_q == CLEAR) fill_mem[clr_addr_q] <= '0;
        else if (ins) fill_mem[s3.h] <= fill_eff + 1'b1;
        if (adv) begin
            rd_ent_q  <= ent_mem[st_q[1].h];
            rd_fill_q <= fill_mem[st_q[1].h];
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            next_id_q   <= '0;
            st_q        <= '0;
            rb_q        <= '0;
            out_valid_q <= 1'b0;
            out_trace_q <= '0;
            out_id_q    <= '0;
            out_new_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            next_id_q   <= next_id_d;
            st_q        <= st_d;
            rb_q        <= rb_d;
            out_valid_q <= out_valid_d;
            out_trace_q <= out_trace_d;
            out_id_q    <= out_id_d;
            out_new_q   <= out_new_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
    assign out_valid    = out_valid_q;
    assign out_trace    = out_trace_q;
    assign out_id       = out_id_q;
    assign out_new      = out_new_q;
    assign out_overflow = out_ovf_q;
    assign busy         = state_q != RUN;
    assign table_full   = &next_id_q;
endmodule

// File: tb/tb_trace_dedup_table.sv
// tb_trace_dedup_table: table-driven scoreboard bench for two configurations sharing 16 buckets:
// A has 2-way buckets and 13-bit IDs, B has 8-way buckets and 3-bit IDs.
module tb_trace_dedup_table;
    typedef struct {
        bit          sel;
        logic [31:0] t;
        logic [3:0]  h;
        logic [12:0] id;
        bit          nw;
        bit          ov;
    } vec_t;
    typedef struct {
        logic [31:0] t;
        logic [12:0] id;
        bit          nw;
        bit          ov;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 0, reset = 0, in_valid = 0, out_ready = 1, clear_req = 0;
    logic [31:0] in_trace = 0;
    logic [3:0]  in_hash = 0;
    bit          sel = 0, lat_en = 1;
    int          cyc = 0, checks = 0, errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        tbl[$];

    logic        a_in_ready, a_out_valid, a_out_new, a_out_ovf, a_busy, a_full;
    logic [31:0] a_out_trace;
    logic [12:0] a_out_id;
    logic        b_in_ready, b_out_valid, b_out_new, b_out_ovf, b_busy, b_full;
    logic [31:0] b_out_trace;
    logic [2:0]  b_out_id;
    logic        m_ready, m_valid, m_new, m_ovf, m_busy, m_full;
    logic [31:0] m_trace;
    logic [12:0] m_id;

    trace_dedup_table #(.TRACE_W(32), .HASH_W(4), .CNT_W(13), .WAYS(2), .RECENT_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_trace(in_trace), .in_hash(in_hash), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_trace(a_out_trace), .out_id(a_out_id), .out_new(a_out_new), .out_overflow(a_out_ovf),
        .clear_req(clear_req && !sel), .busy(a_busy), .table_full(a_full));

    trace_dedup_table #(.TRACE_W(32), .HASH_W(4), .CNT_W(3), .WAYS(8), .RECENT_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .in_trace(in_trace), .in_hash(in_hash), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_trace(b_out_trace), .out_id(b_out_id), .out_new(b_out_new), .out_overflow(b_out_ovf),
        .clear_req(clear_req && sel), .busy(b_busy), .table_full(b_full));

    assign m_ready = sel ? b_in_ready : a_in_ready;
    assign m_valid = sel ? b_out_valid : a_out_valid;
    assign m_new   = sel ? b_out_new : a_out_new;
    assign m_ovf   = sel ? b_out_ovf : a_out_ovf;
    assign m_busy  = sel ? b_busy : a_busy;
    assign m_full  = sel ? b_full : a_full;
    assign m_trace = sel ? b_out_trace : a_out_trace;
    assign m_id    = sel ? {10'd0, b_out_id} : a_out_id;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset && m_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got trace %h id %0h, expected none", m_trace, m_id);
            end else begin
                mon_e = sb.pop_front();
                chk("out_trace", 64'(m_trace), 64'(mon_e.t));
                chk("out_id", 64'(m_id), 64'(mon_e.id));
                chk("out_new", 64'(m_new), 64'(mon_e.nw));
                chk("out_overflow", 64'(m_ovf), 64'(mon_e.ov));
                if (mon_e.lat) chk("latency", 64'(cyc - mon_e.acc), 64'd3);
            end
        end
    end

    task automatic send(input logic [31:0] t, input logic [3:0] h, input logic [12:0] id, input bit nw, input bit ov);
        int n = 0;
        @(negedge clk);
        in_valid = 1;
        in_trace = t;
        in_hash  = h;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 for trace %h, expected 1", t);
        end else begin
            @(posedge clk);
            #1;
            sb.push_back('{t, id, nw, ov, cyc, lat_en});
        end
        in_valid = 0;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            sel = tbl[i].sel;
            send(tbl[i].t, tbl[i].h, tbl[i].id, tbl[i].nw, tbl[i].ov);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || m_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          rdy_seen;
        logic [31:0] snap_t;
        logic [12:0] snap_id;
        tbl.push_back('{1'b0, 32'hDEADBEEF, 4'd3, 13'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'h12345678, 4'd3, 13'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'hDEADBEEF, 4'd3, 13'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'h12345678, 4'd3, 13'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 32'hDEADBEEF, 4'd3, 13'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'hA0000001, 4'd5, 13'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'hA0000002, 4'd5, 13'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'hA0000003, 4'd5, 13'h1FFF, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 32'hA0000003, 4'd5, 13'h1FFF, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 32'hA0000004, 4'd6, 13'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 32'hA0000001, 4'd5, 13'd1, 1'b0, 1'b0});
        for (int i = 0; i < 7; i++)
            tbl.push_back('{1'b1, 32'hB0000000 + 32'(i), 4'(i % 4), 13'(i), 1'b1, 1'b0});
        tbl.push_back('{1'b1, 32'hB0000007, 4'd1, 13'd7, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 32'hB0000000, 4'd0, 13'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 32'hB0000003, 4'd3, 13'd3, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_trace", 64'(a_out_trace), 64'd0);
        chk("rst_out_id", 64'(a_out_id), 64'd0);
        chk("rst_out_flags", 64'({a_out_new, a_out_ovf}), 64'd0);
        chk("rst_busy", 64'({a_busy, b_busy}), 64'd3);
        chk("rst_table_full", 64'({a_full, b_full}), 64'd0);
        reset = 1;
        n = 0;
        while (a_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_clear_cycles", 64'(n), 64'd16);
        chk("ready_after_clear", 64'(a_in_ready), 64'd1);

        run(0, 3);
        drain();

        @(posedge clk);
        #1;
        out_ready = 0;
        lat_en = 0;
        send(32'hCAFE0001, 4'd7, 13'd2, 1'b1, 1'b0);
        send(32'hCAFE0002, 4'd7, 13'd3, 1'b1, 1'b0);
        send(32'hDEADBEEF, 4'd3, 13'd0, 1'b0, 1'b0);
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid", 64'(m_valid), 64'd1);
        snap_t  = m_trace;
        snap_id = m_id;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(m_ready), 64'd0);
            chk("stall_trace", 64'(m_trace), 64'(snap_t));
            chk("stall_id", 64'(m_id), 64'(snap_id));
        end
        chk("stall_first_trace", 64'(snap_t), 64'h00000000CAFE0001);
        @(posedge clk);
        #1;
        out_ready = 1;
        drain();
        lat_en = 1;

        send(32'h55550001, 4'd9, 13'd4, 1'b1, 1'b0);
        send(32'h55550002, 4'd9, 13'd5, 1'b1, 1'b0);
        clear_req = 1;
        @(posedge clk);
        #1;
        clear_req = 0;
        n = 0;
        rdy_seen = 0;
        while (m_busy && n < 100) begin
            @(negedge clk);
            rdy_seen |= m_busy && m_ready;
            n++;
        end
        chk("clear_busy_in_range", 64'(n >= 17 && n <= 24), 64'd1);
        chk("clear_no_ready_while_busy", 64'(rdy_seen), 64'd0);
        chk("clear_drained_first", 64'(sb.size()), 64'd0);
        chk("clear_table_full", 64'(m_full), 64'd0);

        run(4, 10);
        drain();

        sel = 1;
        chk("b_not_full", 64'(m_full), 64'd0);
        run(11, 17);
        drain();
        chk("b_full", 64'(m_full), 64'd1);
        run(18, 20);
        drain();
        chk("b_still_full", 64'(m_full), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
